// File: rtl/multicycle_seq_if.sv
// rtl/multicycle_seq_if.sv - shared memory port between sequencer (master) and memory (slave)
interface multicycle_seq_if;
  logic mem_req;
  logic mem_ready;
  logic mem_fetch;
  logic mem_wr;

  modport master (
    output mem_req,
    output mem_fetch,
    output mem_wr,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_fetch,
    input  mem_wr,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_seq.sv
// rtl/multicycle_seq.sv - one-hot multi-cycle MIPS sequencer (IF/ID/EX/MEM/WB) with shared memory port
// Optional performance counters enabled by defining PERF_CNT_EN.
module multicycle_seq #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  multicycle_seq_if.master     mem,
  input  logic                 dec_mem_read,
  input  logic                 dec_mem_write,
  input  logic                 dec_reg_write,
  input  logic                 dec_branch_taken,
  input  logic                 dec_jump,
  output logic                 ir_wen,
  output logic                 mdr_wen,
  output logic                 pc_wen,
  output logic [1:0]           pc_src,
  output logic                 rf_wen,
  output logic [5:0]           state,
  output logic                 inst_retire,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     inst_cnt
);

  localparam logic [5:0] S_INIT = 6'b000001;
  localparam logic [5:0] S_IF   = 6'b000010;
  localparam logic [5:0] S_ID   = 6'b000100;
  localparam logic [5:0] S_EX   = 6'b001000;
  localparam logic [5:0] S_MEM  = 6'b010000;
  localparam logic [5:0] S_WB   = 6'b100000;

  logic [5:0] state_q;
  logic [5:0] state_d;
  logic       req;
  logic       fetch;
  logic       wr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes decode purely from state so an async reset drops mem_req immediately.
  always_comb begin
    state_d     = state_q;
    req         = 1'b0;
    fetch       = 1'b0;
    wr          = 1'b0;
    ir_wen      = 1'b0;
    mdr_wen     = 1'b0;
    pc_wen      = 1'b0;
    pc_src      = 2'd0;
    rf_wen      = 1'b0;
    inst_retire = 1'b0;
    case (state_q)
      S_INIT: state_d = S_IF;
      S_IF: begin
        req   = 1'b1;
        fetch = 1'b1;
        if (mem.mem_ready) begin
          ir_wen  = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: state_d = S_EX;
      S_EX: begin
        pc_wen = 1'b1;
        if (dec_jump) begin
          pc_src = 2'd2;
        end else if (dec_branch_taken) begin
          pc_src = 2'd1;
        end
        if (dec_mem_read || dec_mem_write) begin
          state_d = S_MEM;
        end else if (dec_reg_write) begin
          state_d = S_WB;
        end else begin
          inst_retire = 1'b1;
          state_d     = S_IF;
        end
      end
      S_MEM: begin
        req = 1'b1;
        wr  = dec_mem_write;
        if (mem.mem_ready) begin
          mdr_wen = dec_mem_read;
          if (dec_reg_write) begin
            state_d = S_WB;
          end else begin
            inst_retire = 1'b1;
            state_d     = S_IF;
          end
        end
      end
      S_WB: begin
        rf_wen      = 1'b1;
        inst_retire = 1'b1;
        state_d     = S_IF;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign mem.mem_req   = req;
  assign mem.mem_fetch = fetch;
  assign mem.mem_wr    = wr;
  assign state         = state_q;

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (inst_retire) begin
        inst_cnt <= inst_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign cycle_cnt = '0;
  assign inst_cnt  = '0;
`endif

endmodule
